pipe_phy_lane_responder: RTL and testbench
==========================================

// Module: pipe_phy_lane_responder
// PURPOSE
//  PHY-side end of the PIPE command/status interface driven by the PCIe MAC (LTSSM TX path).
//  Per lane: answers receiver-detect (TxDetectRx_Loopback) and PowerDown-change requests
//  with PhyStatus/RxStatus handshakes. Also models the post-reset PhyStatus release.
//  Used as the PHY model in MAC-level benches and as the PIPE stub in loopback builds.
// PARAMETERS
//  LANESNUMBER   16       number of lanes
//  LANE_PRESENT  16'hFFFF bit i=1: far-end receiver present on lane i
//  RST_CYCLES    8        PhyStatus held high this many cycles after reset release
//  DETECT_CYCLES 16       cycles from detect request to detect result
//  PD_CYCLES     4        cycles from PowerDown change to PhyStatus pulse
//  MAXPIPEWIDTH  32       data width per lane (loopback feature only)
// PORTS
//  pclk                 in  1                PIPE clock, all logic on rising edge
//  reset                in  1                asynchronous, active-high
//  TxDetectRx_Loopback  in  LANESNUMBER      detect request (P1) / loopback (P0)
//  TxElecIdle           in  LANESNUMBER      MAC transmitter electrical idle
//  PowerDown            in  4*LANESNUMBER    per lane: 0=P0,1=P0s,2=P1,3=P2
//  TxData               in  MAXPIPEWIDTH*LANESNUMBER  MAC transmit data
//  TxDataK              in  (MAXPIPEWIDTH/8)*LANESNUMBER  K-symbol flags
//  TxDataValid          in  LANESNUMBER      transmit data qualifier
//  PhyStatus            out LANESNUMBER      completion pulse / reset-busy
//  RxStatus             out 3*LANESNUMBER    3'b011 detected, 3'b000 otherwise
//  RxElectricalIdle     out LANESNUMBER      1 = no far-end signal on lane
//  RxData/RxDataK/RxDataValid out same widths as Tx counterparts (loopback)
// BEHAVIOUR
//  Reset: PhyStatus=all 1, RxStatus=0, RxElectricalIdle=all 1, Rx data=0, all lanes in RST.
//  Per-lane FSM, one shared reset counter:
//   RST    : PhyStatus=1; after RST_CYCLES cycles from reset release -> IDLE, PhyStatus=0.
//   IDLE   : on rising edge of TxDetectRx_Loopback with PowerDown==2 and TxElecIdle==1
//            -> DETECT. On PowerDown != registered value -> PDCHG.
//            Detect edge in any other power state or with TxElecIdle==0 is ignored.
//   DETECT : counts DETECT_CYCLES. Then one-cycle PhyStatus=1 with RxStatus=3'b011 if
//            LANE_PRESENT[i] else 3'b000. -> HOLD.
//   HOLD   : wait for TxDetectRx_Loopback==0 -> IDLE. A new detect needs a fresh edge.
//   PDCHG  : counts PD_CYCLES, latches new PowerDown at entry. Then one-cycle PhyStatus=1,
//            RxStatus=0. -> IDLE.
//  Latency: detect result in cycle DETECT_CYCLES+1 after the request edge.
//  PowerDown-change completion is in cycle PD_CYCLES+1 after the change.
//  RxStatus is nonzero only in the PhyStatus pulse cycle.
//  Simultaneous: detect edge and PowerDown change in the same IDLE cycle -> detect wins.
//   A PowerDown change during DETECT/HOLD/PDCHG is held pending (last value wins).
//   It is serviced from IDLE on the next cycle, one pulse per service.
//  PowerDown values >3: registered value unchanged, no pulse.
//  RxElectricalIdle[i] = ~LANE_PRESENT[i] | (registered PowerDown != 0), registered.
//  Reset asserted mid-operation: lane aborts, outputs return to reset values, restarts in RST.
//  Lanes are independent. Counters wrap-free: saturate at terminal count and reset on state entry.
// CONFIGURATION
//  PIPE_PHY_LOOPBACK_EN defined: lane in P0 with TxDetectRx_Loopback=1 and LANE_PRESENT[i]
//   echoes TxData/TxDataK/TxDataValid to RxData/RxDataK/RxDataValid, 1-cycle latency.
//   RxElectricalIdle is forced 0 on that lane.
//  Not defined: Rx data outputs tied 0 and Tx data inputs unused. Loopback never entered.
// TESTING
//  1 Release reset -> PhyStatus all 1 for exactly 8 cycles, then 0; RxStatus=0 throughout.
//  2 PowerDown=2, TxElecIdle=1, detect on all lanes, LANE_PRESENT=16'h00FF
//    -> cycle 17: PhyStatus=16'hFFFF one cycle; RxStatus 3'b011 on lanes 0-7, 3'b000 on 8-15.
//  3 Lane 0 PowerDown 2->0 -> PhyStatus[0] pulses at cycle 5, RxElectricalIdle[0] -> 0.
//    Other lanes are unaffected.
//  4 Detect edge with PowerDown=0 (loopback off) -> no PhyStatus, no RxStatus change
//    for 40 cycles.
//  5 PowerDown change issued 3 cycles into DETECT -> detect pulse at cycle 17, then a PDCHG
//    pulse 5 cycles after returning to IDLE (needs detect dropped).
//  6 Reset asserted at DETECT cycle 10 -> immediate PhyStatus=all 1, RxStatus=0;
//    no stale detect pulse after release.
//    With PIPE_PHY_LOOPBACK_EN: P0 loopback, TxData=32'hA5A5_0F0F -> RxData equal
//    one cycle later.

Source files
------------

// File: rtl/pipe_phy_lane_responder.sv
// pipe_phy_lane_responder: per-lane PIPE PHY stub answering receiver-detect and PowerDown handshakes.
// Optional P0 loopback echo of Tx data enabled by `define PIPE_PHY_LOOPBACK_EN.
module pipe_phy_lane_responder #(
  parameter int LANESNUMBER = 16,
  parameter logic [LANESNUMBER-1:0] LANE_PRESENT = '1,
  parameter int RST_CYCLES = 8,
  parameter int DETECT_CYCLES = 16,
  parameter int PD_CYCLES = 4,
  parameter int MAXPIPEWIDTH = 32
) (
  input  logic                                      pclk,
  input  logic                                      reset,
  input  logic [LANESNUMBER-1:0]                    TxDetectRx_Loopback,
  input  logic [LANESNUMBER-1:0]                    TxElecIdle,
  input  logic [4*LANESNUMBER-1:0]                  PowerDown,
  input  logic [MAXPIPEWIDTH*LANESNUMBER-1:0]       TxData,
  input  logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0]   TxDataK,
  input  logic [LANESNUMBER-1:0]                    TxDataValid,
  output logic [LANESNUMBER-1:0]                    PhyStatus,
  output logic [3*LANESNUMBER-1:0]                  RxStatus,
  output logic [LANESNUMBER-1:0]                    RxElectricalIdle,
  output logic [MAXPIPEWIDTH*LANESNUMBER-1:0]       RxData,
  output logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0]   RxDataK,
  output logic [LANESNUMBER-1:0]                    RxDataValid
);
  localparam int KW = MAXPIPEWIDTH / 8;
  localparam int CW = $clog2((DETECT_CYCLES > PD_CYCLES ? DETECT_CYCLES : PD_CYCLES) + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  typedef enum logic [2:0] {RST, IDLE, DETECT, HOLD, PDCHG} state_t;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic rst_done;
  assign rst_done = rst_cnt_q == RW'(RST_CYCLES);
  assign rst_cnt_d = rst_done ? rst_cnt_q : rst_cnt_q + 1'b1;
  always_ff @(posedge pclk or posedge reset)
    if (reset) rst_cnt_q <= '0;
    else rst_cnt_q <= rst_cnt_d;
  for (genvar i = 0; i < LANESNUMBER; i++) begin : g_lane
    state_t st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] pd_in, pd_q, pd_d;
    logic [2:0] rs_q, rs_d;
    logic det_q, det_ok, pd_chg, pulse, lb, phy_q, phy_d, ei_q, ei_d;
    assign pd_in = PowerDown[4*i +: 4];
    assign det_ok = TxDetectRx_Loopback[i] & ~det_q & (pd_in == 4'd2) & TxElecIdle[i];
    assign pd_chg = (pd_in < 4'd4) & (pd_in != pd_q);
    always_comb begin
      st_d = st_q;
      cnt_d = cnt_q;
      pd_d = pd_q;
      pulse = 1'b0;
      rs_d = 3'b000;
      case (st_q)
        RST: st_d = rst_done ? IDLE : RST;
        IDLE:
          if (det_ok) begin
            st_d = DETECT;
            cnt_d = '0;
          end else if (pd_chg) begin
            st_d = PDCHG;
            cnt_d = '0;
            pd_d = pd_in;
          end
        DETECT:
          if (cnt_q == CW'(DETECT_CYCLES - 1)) begin
            st_d = HOLD;
            pulse = 1'b1;
            rs_d = LANE_PRESENT[i] ? 3'b011 : 3'b000;
          end else cnt_d = cnt_q + 1'b1;
        HOLD: st_d = TxDetectRx_Loopback[i] ? HOLD : IDLE;
        PDCHG:
          if (cnt_q == CW'(PD_CYCLES - 1)) begin
            st_d = IDLE;
            pulse = 1'b1;
          end else cnt_d = cnt_q + 1'b1;
        default: st_d = RST;
      endcase
      phy_d = pulse | (st_d == RST);
      ei_d = ~lb & (~LANE_PRESENT[i] | (pd_q != 4'd0));
    end
    always_ff @(posedge pclk or posedge reset)
      if (reset) begin
        st_q <= RST;
        cnt_q <= '0;
        pd_q <= 4'd2;
        det_q <= 1'b0;
        phy_q <= 1'b1;
        rs_q <= 3'b000;
        ei_q <= 1'b1;
      end else begin
        st_q <= st_d;
        cnt_q <= cnt_d;
        pd_q <= pd_d;
        det_q <= TxDetectRx_Loopback[i];
        phy_q <= phy_d;
        rs_q <= rs_d;
        ei_q <= ei_d;
      end
    assign PhyStatus[i] = phy_q;
    assign RxStatus[3*i +: 3] = rs_q;
    assign RxElectricalIdle[i] = ei_q;
`ifdef PIPE_PHY_LOOPBACK_EN
    logic [MAXPIPEWIDTH-1:0] rxd_q, rxd_d;
    logic [KW-1:0] rxk_q, rxk_d;
    logic rxv_q, rxv_d;
    assign lb = (pd_q == 4'd0) & TxDetectRx_Loopback[i] & LANE_PRESENT[i];
    always_comb begin
      rxd_d = lb ? TxData[MAXPIPEWIDTH*i +: MAXPIPEWIDTH] : '0;
      rxk_d = lb ? TxDataK[KW*i +: KW] : '0;
      rxv_d = lb & TxDataValid[i];
    end
    always_ff @(posedge pclk or posedge reset)
      if (reset) begin
        rxd_q <= '0;
        rxk_q <= '0;
        rxv_q <= 1'b0;
      end else begin
        rxd_q <= rxd_d;
        rxk_q <= rxk_d;
        rxv_q <= rxv_d;
      end
    assign RxData[MAXPIPEWIDTH*i +: MAXPIPEWIDTH] = rxd_q;
    assign RxDataK[KW*i +: KW] = rxk_q;
    assign RxDataValid[i] = rxv_q;
`else
    assign lb = 1'b0;
`endif
  end
`ifndef PIPE_PHY_LOOPBACK_EN
  logic unused_tx;
  assign unused_tx = ^{TxData, TxDataK, TxDataValid};
  assign RxData = '0;
  assign RxDataK = '0;
  assign RxDataValid = '0;
`endif
endmodule

// File: tb/tb_pipe_phy_lane_responder.sv
// tb_pipe_phy_lane_responder: directed bench with a cycle-timeline model of the PIPE PHY responder.
module tb_pipe_phy_lane_responder;
  localparam int L = 16;
  localparam int W = 32;
  localparam int KW = W / 8;
  localparam int RSTC = 8;
  localparam int DETC = 16;
  localparam int PDC = 4;
  localparam logic [L-1:0] PRESENT = 16'h00FF;
  logic pclk = 1'b0;
  logic reset;
  logic [L-1:0] TxDetectRx_Loopback, TxElecIdle, TxDataValid;
  logic [4*L-1:0] PowerDown;
  logic [W*L-1:0] TxData;
  logic [KW*L-1:0] TxDataK;
  logic [L-1:0] PhyStatus, RxElectricalIdle, RxDataValid;
  logic [3*L-1:0] RxStatus;
  logic [W*L-1:0] RxData;
  logic [KW*L-1:0] RxDataK;
  int tests = 0;
  int fails = 0;
  int e;
  int pulse_e[L];
  bit holding[L];
  bit kind_det[L];
  bit det_prev[L];
  logic [3:0] pd_reg[L];
  logic [L-1:0] exp_phy, exp_ei, exp_rxv;
  logic [3*L-1:0] exp_rs;
  logic [W*L-1:0] exp_rxd;
  logic [KW*L-1:0] exp_rxk;
  logic [L-1:0] acc;
  pipe_phy_lane_responder #(
    .LANESNUMBER(L), .LANE_PRESENT(PRESENT), .RST_CYCLES(RSTC),
    .DETECT_CYCLES(DETC), .PD_CYCLES(PDC), .MAXPIPEWIDTH(W)
  ) dut (
    .pclk(pclk), .reset(reset), .TxDetectRx_Loopback(TxDetectRx_Loopback),
    .TxElecIdle(TxElecIdle), .PowerDown(PowerDown), .TxData(TxData), .TxDataK(TxDataK),
    .TxDataValid(TxDataValid), .PhyStatus(PhyStatus), .RxStatus(RxStatus),
    .RxElectricalIdle(RxElectricalIdle), .RxData(RxData), .RxDataK(RxDataK),
    .RxDataValid(RxDataValid)
  );
  always #5 pclk = ~pclk;
  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask
  // Timeline model: each lane is busy until its scheduled pulse edge, then free (or holding for detect drop).
  task automatic run_model();
    forever begin
      @(posedge pclk);
      if (reset) begin
        e = 0;
        for (int i = 0; i < L; i++) begin
          pulse_e[i] = -1;
          holding[i] = 1'b0;
          kind_det[i] = 1'b0;
          det_prev[i] = 1'b0;
          pd_reg[i] = 4'd2;
        end
        exp_phy = '1;
        exp_rs = '0;
        exp_ei = '1;
        exp_rxd = '0;
        exp_rxk = '0;
        exp_rxv = '0;
      end else begin
        e++;
        for (int i = 0; i < L; i++) begin
          logic [3:0] pin;
          logic din, lb;
          pin = PowerDown[4*i +: 4];
          din = TxDetectRx_Loopback[i];
          lb = 1'b0;
`ifdef PIPE_PHY_LOOPBACK_EN
          lb = (pd_reg[i] == 4'd0) && din && PRESENT[i];
`endif
          exp_ei[i] = lb ? 1'b0 : (!PRESENT[i] || pd_reg[i] != 4'd0);
          exp_rxd[W*i +: W] = lb ? TxData[W*i +: W] : '0;
          exp_rxk[KW*i +: KW] = lb ? TxDataK[KW*i +: KW] : '0;
          exp_rxv[i] = lb && TxDataValid[i];
          if (e >= RSTC + 2 && !holding[i] && e > pulse_e[i]) begin
            if (din && !det_prev[i] && pin == 4'd2 && TxElecIdle[i]) begin
              pulse_e[i] = e + DETC;
              kind_det[i] = 1'b1;
              holding[i] = 1'b1;
            end else if (pin <= 4'd3 && pin != pd_reg[i]) begin
              pulse_e[i] = e + PDC;
              kind_det[i] = 1'b0;
              pd_reg[i] = pin;
            end
          end else if (holding[i] && e > pulse_e[i] && !din) holding[i] = 1'b0;
          det_prev[i] = din;
          exp_phy[i] = (e <= RSTC) || (e == pulse_e[i]);
          exp_rs[3*i +: 3] = (e == pulse_e[i] && kind_det[i] && PRESENT[i]) ? 3'b011 : 3'b000;
        end
      end
      #1;
      chk("model PhyStatus", 512'(PhyStatus), 512'(exp_phy));
      chk("model RxStatus", 512'(RxStatus), 512'(exp_rs));
      chk("model RxElectricalIdle", 512'(RxElectricalIdle), 512'(exp_ei));
      chk("model RxData", RxData, exp_rxd);
      chk("model RxDataK", 512'(RxDataK), 512'(exp_rxk));
      chk("model RxDataValid", 512'(RxDataValid), 512'(exp_rxv));
    end
  endtask
  initial begin
    reset = 1'b1;
    PowerDown = {L{4'd2}};
    TxElecIdle = '1;
    TxDetectRx_Loopback = '0;
    TxData = '0;
    TxDataK = '0;
    TxDataValid = '0;
    fork
      run_model();
    join_none
    step(3);
    reset = 1'b0;
    for (int k = 1; k <= RSTC; k++) begin
      step(1);
      chk("rst PhyStatus high", 512'(PhyStatus), 512'(16'hFFFF));
      chk("rst RxStatus zero", 512'(RxStatus), 512'(0));
    end
    step(1);
    chk("rst PhyStatus released", 512'(PhyStatus), 512'(0));
    TxDetectRx_Loopback = '1;
    step(16);
    chk("detect pre-pulse", 512'(PhyStatus), 512'(0));
    step(1);
    chk("detect PhyStatus", 512'(PhyStatus), 512'(16'hFFFF));
    chk("detect RxStatus", 512'(RxStatus), 512'(48'h0000_006D_B6DB));
    step(1);
    chk("detect pulse ends", 512'(PhyStatus | 16'(RxStatus)), 512'(0));
    TxDetectRx_Loopback = '0;
    step(2);
    PowerDown[3:0] = 4'd0;
    step(4);
    chk("pd lane0 pre-pulse", 512'(PhyStatus), 512'(0));
    step(1);
    chk("pd lane0 PhyStatus", 512'(PhyStatus), 512'(16'h0001));
    chk("pd lane0 RxStatus", 512'(RxStatus), 512'(0));
    chk("pd lane0 RxElectricalIdle", 512'(RxElectricalIdle), 512'(16'hFFFE));
    step(1);
    PowerDown = {L{4'd0}};
    step(6);
    TxDetectRx_Loopback = '1;
    TxData = {L{32'h1234_5678}};
    TxDataK = '1;
    TxDataValid = '1;
    acc = '0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      acc = acc | PhyStatus | 16'(RxStatus) | 16'(RxStatus >> 16) | 16'(RxStatus >> 32);
    end
    chk("detect in P0 ignored", 512'(acc), 512'(0));
    chk("P0 RxElectricalIdle", 512'(RxElectricalIdle), 512'(16'hFF00));
    TxDetectRx_Loopback = '0;
    TxData = '0;
    TxDataK = '0;
    TxDataValid = '0;
    step(2);
    PowerDown = {L{4'd2}};
    step(7);
    TxDetectRx_Loopback = '1;
    step(3);
    PowerDown = {L{4'd3}};
    step(13);
    chk("pending pre-pulse", 512'(PhyStatus), 512'(0));
    step(1);
    chk("pending detect PhyStatus", 512'(PhyStatus), 512'(16'hFFFF));
    chk("pending detect RxStatus", 512'(RxStatus), 512'(48'h0000_006D_B6DB));
    step(2);
    TxDetectRx_Loopback = '0;
    step(5);
    chk("pending pd pre-pulse", 512'(PhyStatus), 512'(0));
    step(1);
    chk("pending pd PhyStatus", 512'(PhyStatus), 512'(16'hFFFF));
    chk("pending pd RxStatus", 512'(RxStatus), 512'(0));
    step(1);
    PowerDown = {L{4'd2}};
    step(7);
    TxDetectRx_Loopback = '1;
    step(10);
    reset = 1'b1;
    #1;
    chk("abort PhyStatus", 512'(PhyStatus), 512'(16'hFFFF));
    chk("abort RxStatus", 512'(RxStatus), 512'(0));
    chk("abort RxElectricalIdle", 512'(RxElectricalIdle), 512'(16'hFFFF));
    step(2);
    reset = 1'b0;
    acc = '0;
    for (int k = 1; k <= 30; k++) begin
      step(1);
      if (k > RSTC) acc = acc | PhyStatus | 16'(RxStatus) | 16'(RxStatus >> 16) | 16'(RxStatus >> 32);
    end
    chk("no stale detect", 512'(acc), 512'(0));
    TxDetectRx_Loopback = '0;
    step(2);
`ifdef PIPE_PHY_LOOPBACK_EN
    PowerDown[3:0] = 4'd0;
    step(7);
    TxDetectRx_Loopback = 16'h0001;
    TxData[31:0] = 32'hA5A5_0F0F;
    TxDataK[3:0] = 4'h5;
    TxDataValid[0] = 1'b1;
    step(1);
    chk("loopback RxData", 512'(RxData[31:0]), 512'(32'hA5A5_0F0F));
    chk("loopback RxDataK", 512'(RxDataK[3:0]), 512'(4'h5));
    chk("loopback RxDataValid", 512'(RxDataValid[0]), 512'(1'b1));
    chk("loopback RxElectricalIdle", 512'(RxElectricalIdle[0]), 512'(1'b0));
    step(2);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
